// File: rtl/vt_pkg.sv
// rtl/vt_pkg.sv - shared types, ASCII constants and byte classifiers for the VT escape parser
package vt_pkg;
  localparam int ROWS_DEF    = 24;
  localparam int COLS_DEF    = 80;
  localparam int NUM_MAX_DEF = 255;

  localparam logic [7:0] ESC       = 8'h1B;
  localparam logic [7:0] CAN       = 8'h18;
  localparam logic [7:0] SUB       = 8'h1A;
  localparam logic [7:0] CSI_INTRO = 8'h5B;

  typedef enum logic [3:0] {
    OP_NOP, PRINT, CR, LF, BS, RI, RIS, CUU, CUD, CUF, CUB, CUP, ED, EL
  } op_t;

  typedef enum logic [1:0] {
    S_GROUND, S_ESC, S_CSI_PARAM, S_CSI_IGNORE
  } state_t;

  // C0 bytes that produce a command in every state; OP_NOP means "no command".
  function automatic op_t c0_op(input logic [7:0] b);
    case (b)
      8'h0D:               c0_op = CR;
      8'h0A, 8'h0B, 8'h0C: c0_op = LF;
      8'h08:               c0_op = BS;
      default:             c0_op = OP_NOP;
    endcase
  endfunction

  function automatic logic is_final(input logic [7:0] b);
    return (b >= 8'h40) && (b <= 8'h7E);
  endfunction
endpackage

// File: rtl/vt_escape_parser_if.sv
// rtl/vt_escape_parser_if.sv - host byte stream and decoded command stream of the VT parser
interface vt_escape_parser_if;
  import vt_pkg::*;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_byte;
  logic       cmd_valid;
  logic       cmd_ready;
  op_t        cmd_op;
  logic [7:0] cmd_n;
  logic [4:0] cmd_row;
  logic [6:0] cmd_col;

  modport master (
    output in_valid, in_byte, cmd_ready,
    input  in_ready, cmd_valid, cmd_op, cmd_n, cmd_row, cmd_col
  );

  modport slave (
    input  in_valid, in_byte, cmd_ready,
    output in_ready, cmd_valid, cmd_op, cmd_n, cmd_row, cmd_col
  );
endinterface

// File: rtl/vt_escape_parser_csi_param_acc.sv
// rtl/vt_escape_parser_csi_param_acc.sv - two saturating decimal CSI parameter accumulators
module csi_param_acc #(
  parameter int NUM_MAX = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       digit_i,
  input  logic [3:0] digit_val_i,
  input  logic       sep_i,
  output logic [7:0] p0_o,
  output logic [7:0] p1_o
);
  logic [7:0] p0_q, p0_d, p1_q, p1_d;
  logic [1:0] idx_q, idx_d;

  // Wide enough for 255*10+9 so saturation never sees a wrapped value.
  function automatic logic [7:0] mac(input logic [7:0] p, input logic [3:0] d);
    logic [11:0] t;
    t = ({4'd0, p} * 12'd10) + {8'd0, d};
    return (t > 12'(NUM_MAX)) ? 8'(NUM_MAX) : t[7:0];
  endfunction

  always_comb begin
    p0_d  = p0_q;
    p1_d  = p1_q;
    idx_d = idx_q;
    if (clear_i) begin
      p0_d  = '0;
      p1_d  = '0;
      idx_d = '0;
    end else if (digit_i) begin
      if (idx_q == 2'd0)      p0_d = mac(p0_q, digit_val_i);
      else if (idx_q == 2'd1) p1_d = mac(p1_q, digit_val_i);
    end else if (sep_i && idx_q != 2'd2) begin
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p0_q  <= '0;
      p1_q  <= '0;
      idx_q <= '0;
    end else begin
      p0_q  <= p0_d;
      p1_q  <= p1_d;
      idx_q <= idx_d;
    end
  end

  assign p0_o = p0_q;
  assign p1_o = p1_q;
endmodule

// File: rtl/vt_escape_parser.sv
// rtl/vt_escape_parser.sv - host byte stream to terminal command decoder (ESC/CSI parser FSM + cmd register)
module vt_escape_parser
  import vt_pkg::*;
#(
  parameter int ROWS    = ROWS_DEF,
  parameter int COLS    = COLS_DEF,
  parameter int NUM_MAX = NUM_MAX_DEF
) (
  input logic               clk,
  input logic               reset,
  vt_escape_parser_if.slave bus
);
  state_t     state_q, state_d;
  logic       cmd_valid_q;
  op_t        op_q, op_d;
  logic [7:0] n_q, n_d;
  logic [4:0] row_q, row_d;
  logic [6:0] col_q, col_d;
  logic       load;
  logic       take;
  logic [7:0] b;
  logic       acc_clear, acc_digit, acc_sep;
  logic [7:0] p0, p1, p0n, p1n;
  op_t        c0;

  assign b            = bus.in_byte;
  assign bus.in_ready = ~cmd_valid_q | bus.cmd_ready;
  assign take         = bus.in_valid & bus.in_ready;
  assign c0           = c0_op(b);
  assign p0n          = (p0 == 8'd0) ? 8'd1 : p0;
  assign p1n          = (p1 == 8'd0) ? 8'd1 : p1;

  csi_param_acc #(.NUM_MAX(NUM_MAX)) u_acc (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (acc_clear),
    .digit_i    (acc_digit),
    .digit_val_i(b[3:0]),
    .sep_i      (acc_sep),
    .p0_o       (p0),
    .p1_o       (p1)
  );

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    op_d      = OP_NOP;
    n_d       = '0;
    row_d     = '0;
    col_d     = '0;
    acc_clear = 1'b0;
    acc_digit = 1'b0;
    acc_sep   = 1'b0;
    if (take) begin
      if (state_q == S_GROUND) begin
        if (b >= 8'h20 && b <= 8'h7E) begin
          load = 1'b1;
          op_d = PRINT;
          n_d  = b;
        end else if (b == ESC) begin
          state_d = S_ESC;
        end else if (c0 != OP_NOP) begin
          load = 1'b1;
          op_d = c0;
        end
      end else if (b == CAN || b == SUB) begin
        state_d = S_GROUND;
      end else if (b == ESC) begin
        state_d = S_ESC;
      end else if (b < 8'h20) begin
        // Formatting controls inside a sequence act immediately and leave it intact.
        if (c0 != OP_NOP) begin
          load = 1'b1;
          op_d = c0;
        end
      end else begin
        case (state_q)
          S_ESC: begin
            state_d = S_GROUND;
            if (b == CSI_INTRO) begin
              state_d   = S_CSI_PARAM;
              acc_clear = 1'b1;
            end else if (b == 8'h63) begin
              load = 1'b1;
              op_d = RIS;
            end else if (b == 8'h44) begin
              load = 1'b1;
              op_d = LF;
            end else if (b == 8'h4D) begin
              load = 1'b1;
              op_d = RI;
            end
          end
          S_CSI_PARAM: begin
            if (b >= 8'h30 && b <= 8'h39) begin
              acc_digit = 1'b1;
            end else if (b == 8'h3B) begin
              acc_sep = 1'b1;
            end else if (b < 8'h40) begin
              // Intermediates, ':' and private markers: sequence is not ours.
              state_d = S_CSI_IGNORE;
            end else if (is_final(b)) begin
              state_d = S_GROUND;
              case (b)
                8'h41: begin load = 1'b1; op_d = CUU; n_d = p0n; end
                8'h42: begin load = 1'b1; op_d = CUD; n_d = p0n; end
                8'h43: begin load = 1'b1; op_d = CUF; n_d = p0n; end
                8'h44: begin load = 1'b1; op_d = CUB; n_d = p0n; end
                8'h48, 8'h66: begin
                  load  = 1'b1;
                  op_d  = CUP;
                  row_d = 5'((p0n > 8'(ROWS)) ? 8'(ROWS - 1) : p0n - 8'd1);
                  col_d = 7'((p1n > 8'(COLS)) ? 8'(COLS - 1) : p1n - 8'd1);
                end
                8'h4A: if (p0 <= 8'd2) begin load = 1'b1; op_d = ED; n_d = p0; end
                8'h4B: if (p0 <= 8'd2) begin load = 1'b1; op_d = EL; n_d = p0; end
                default: ;
              endcase
            end
          end
          S_CSI_IGNORE: if (is_final(b)) state_d = S_GROUND;
          default: state_d = S_GROUND;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_GROUND;
    else       state_q <= state_d;
  end

  // A load while draining overwrites in place, so cmd_valid stays high with no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_valid_q <= 1'b0;
      op_q        <= OP_NOP;
      n_q         <= '0;
      row_q       <= '0;
      col_q       <= '0;
    end else if (load) begin
      cmd_valid_q <= 1'b1;
      op_q        <= op_d;
      n_q         <= n_d;
      row_q       <= row_d;
      col_q       <= col_d;
    end else if (bus.cmd_ready) begin
      cmd_valid_q <= 1'b0;
    end
  end

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_op    = op_q;
  assign bus.cmd_n     = n_q;
  assign bus.cmd_row   = row_q;
  assign bus.cmd_col   = col_q;
endmodule

// File: tb/tb_vt_escape_parser.sv
// tb/tb_vt_escape_parser.sv - directed table-driven bench for vt_escape_parser
module tb_vt_escape_parser;
  import vt_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vt_escape_parser_if bus();
  vt_escape_parser dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    op_t        op;
    logic [7:0] n;
    logic [4:0] row;
    logic [6:0] col;
    int         cyc;
  } rec_t;

  typedef struct {
    logic [95:0] seq;
    int          len;
    int          cnt;
    op_t         op;
    logic [7:0]  n;
    logic [4:0]  row;
    logic [6:0]  col;
  } vec_t;

  rec_t mon_q[$];
  vec_t vecs[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rec_t r;
    #2;
    if (!reset && bus.cmd_valid && bus.cmd_ready) begin
      r.op  = bus.cmd_op;
      r.n   = bus.cmd_n;
      r.row = bus.cmd_row;
      r.col = bus.cmd_col;
      r.cyc = cyc;
      mon_q.push_back(r);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic check_rec(input string name, input rec_t r, input op_t op,
                           input logic [7:0] n, input logic [4:0] row, input logic [6:0] col);
    chk({name, ".op"}, 32'(r.op), 32'(op));
    if (op inside {PRINT, CUU, CUD, CUF, CUB, ED, EL}) chk({name, ".n"}, 32'(r.n), 32'(n));
    if (op == CUP) begin
      chk({name, ".row"}, 32'(r.row), 32'(row));
      chk({name, ".col"}, 32'(r.col), 32'(col));
    end
  endtask

  task automatic add(input logic [95:0] seq, input int len, input int cnt, input op_t op,
                     input logic [7:0] n, input logic [4:0] row, input logic [6:0] col);
    vec_t v;
    v.seq = seq; v.len = len; v.cnt = cnt; v.op = op; v.n = n; v.row = row; v.col = col;
    vecs.push_back(v);
  endtask

  // Call at a negedge; returns at the negedge right after the byte is taken.
  task automatic send(input logic [7:0] b);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      total++;
      $display("FAIL send_timeout: in_ready stayed 0 for byte %0h, required 1", b);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_byte   = 8'h00;
    bus.cmd_ready = 1'b1;

    add({8'h1B, "[12;40H"},        8, 1, CUP,   8'd0,   5'd11, 7'd39);
    add({8'h1B, "[H"},             3, 1, CUP,   8'd0,   5'd0,  7'd0);
    add({8'h1B, "[99;200H"},       9, 1, CUP,   8'd0,   5'd23, 7'd79);
    add({8'h1B, "[5A"},            4, 1, CUU,   8'd5,   5'd0,  7'd0);
    add({8'h1B, "[C"},             3, 1, CUF,   8'd1,   5'd0,  7'd0);
    add({8'h1B, "[0D"},            4, 1, CUB,   8'd1,   5'd0,  7'd0);
    add({8'h1B, "[999B"},          6, 1, CUD,   8'd255, 5'd0,  7'd0);
    add({8'h1B, "[2J"},            4, 1, ED,    8'd2,   5'd0,  7'd0);
    add({8'h1B, "[K"},             3, 1, EL,    8'd0,   5'd0,  7'd0);
    add({8'h1B, "[7J"},            4, 0, OP_NOP, 8'd0,  5'd0,  7'd0);
    add({8'h1B, "[?25h"},          6, 0, OP_NOP, 8'd0,  5'd0,  7'd0);
    add({8'h1B, "[1;2;3m"},        8, 0, OP_NOP, 8'd0,  5'd0,  7'd0);
    add({8'h1B, "[1", 8'h18, "A"}, 5, 1, PRINT, 8'h41,  5'd0,  7'd0);
    add({8'h1B, "c"},              2, 1, RIS,   8'd0,   5'd0,  7'd0);
    add({8'h1B, "M"},              2, 1, RI,    8'd0,   5'd0,  7'd0);
    add({8'h1B, "D"},              2, 1, LF,    8'd0,   5'd0,  7'd0);
    add({8'h1B, "[5;7f"},          6, 1, CUP,   8'd0,   5'd4,  7'd6);
    add({8'h07, 8'h80, 8'h7F},     3, 0, OP_NOP, 8'd0,  5'd0,  7'd0);
    add({8'h1B, "[1;2;3H"},        8, 1, CUP,   8'd0,   5'd0,  7'd1);
    add({8'h08},                   1, 1, BS,    8'd0,   5'd0,  7'd0);
    add({8'h1B, "[3;", 8'h1B, "[4B"}, 8, 1, CUD, 8'd4,  5'd0,  7'd0);

    repeat (3) @(negedge clk);
    #2;
    chk("reset.cmd_valid", 32'(bus.cmd_valid), 32'd0);
    chk("reset.cmd_op",    32'(bus.cmd_op),    32'(OP_NOP));
    chk("reset.fields",    32'({bus.cmd_n, bus.cmd_row, bus.cmd_col}), 32'd0);
    chk("reset.in_ready",  32'(bus.in_ready),  32'd1);
    @(negedge clk);
    reset = 1'b0;

    // "Hi\r\n" back to back
    mon_q.delete();
    send(8'h48); send(8'h69); send(8'h0D); send(8'h0A);
    idle(3);
    chk("hi.count", 32'(mon_q.size()), 32'd4);
    if (mon_q.size() == 4) begin
      check_rec("hi0", mon_q[0], PRINT, 8'h48, 5'd0, 7'd0);
      check_rec("hi1", mon_q[1], PRINT, 8'h69, 5'd0, 7'd0);
      check_rec("hi2", mon_q[2], CR,    8'h00, 5'd0, 7'd0);
      check_rec("hi3", mon_q[3], LF,    8'h00, 5'd0, 7'd0);
      chk("hi.span", 32'(mon_q[3].cyc - mon_q[0].cyc), 32'd3);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      mon_q.delete();
      for (int k = 0; k < vecs[i].len; k++)
        send(vecs[i].seq[8*(vecs[i].len-1-k) +: 8]);
      idle(3);
      chk($sformatf("vec%0d.count", i), 32'(mon_q.size()), 32'(vecs[i].cnt));
      if (vecs[i].cnt == 1 && mon_q.size() >= 1)
        check_rec($sformatf("vec%0d", i), mon_q[0], vecs[i].op, vecs[i].n, vecs[i].row, vecs[i].col);
    end

    // CR inside a CSI keeps the parameters
    mon_q.delete();
    send(8'h1B); send(8'h5B); send(8'h33); send(8'h0D); send(8'h42);
    idle(3);
    chk("crmid.count", 32'(mon_q.size()), 32'd2);
    if (mon_q.size() == 2) begin
      check_rec("crmid0", mon_q[0], CR,  8'd0, 5'd0, 7'd0);
      check_rec("crmid1", mon_q[1], CUD, 8'd3, 5'd0, 7'd0);
    end

    // Backpressure, then same-cycle drain and replace
    mon_q.delete();
    bus.cmd_ready = 1'b0;
    send(8'h58);
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'h59;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #2;
      chk($sformatf("hold%0d", k), 32'({bus.in_ready, bus.cmd_valid, bus.cmd_op, bus.cmd_n}),
          32'({1'b0, 1'b1, PRINT, 8'h58}));
    end
    @(negedge clk);
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    idle(3);
    chk("bp.count", 32'(mon_q.size()), 32'd2);
    if (mon_q.size() == 2) begin
      check_rec("bp0", mon_q[0], PRINT, 8'h58, 5'd0, 7'd0);
      check_rec("bp1", mon_q[1], PRINT, 8'h59, 5'd0, 7'd0);
      chk("bp.span", 32'(mon_q[1].cyc - mon_q[0].cyc), 32'd1);
    end

    // Reset in the middle of ESC[4
    mon_q.delete();
    send(8'h1B); send(8'h5B); send(8'h34);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("rstmid.cmd_valid", 32'(bus.cmd_valid), 32'd0);
    chk("rstmid.cmd_op",    32'(bus.cmd_op),    32'(OP_NOP));
    @(negedge clk);
    reset = 1'b0;
    send(8'h41);
    idle(3);
    chk("rstmid.count", 32'(mon_q.size()), 32'd1);
    if (mon_q.size() == 1) check_rec("rstmid", mon_q[0], PRINT, 8'h41, 5'd0, 7'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
